// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer:
// FSM state encodings, PC-select codes and default widths/constants.
package fetch_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned INSTR_W        = 32;
  localparam int unsigned IMEM_DEPTH_DEF = 1024;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

  // PC mux steering codes
  localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SEL_TARGET = 2'd1;
  localparam logic [1:0] PC_SEL_RESET  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READY = 3'd2,
    ST_BOOT  = 3'd3,
    ST_RUN   = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  // States in which the NoC loader may hand over a program word
  function automatic logic accepts_load(state_t s);
    return (s == ST_IDLE) || (s == ST_LOAD) || (s == ST_HALT);
  endfunction

endpackage

// File: rtl/fetch_ctrl_imem_loader.sv
// Program-image loader: load handshake, word counter, IMEM write address
// generation and sticky overflow flag.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load_valid/ready  NoC word handshake (ready is owned by the FSM)
//   load_data         program word
//   restart           reload from HALT: write at address 0, count restarts
//   handshake         word consumed this cycle
//   imem_we/waddr/wdata  instruction memory write port
//   load_count        words written so far (saturates at IMEM_DEPTH)
//   load_error        sticky: a word arrived with the memory already full
module imem_loader
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = INSTR_W,
  parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_valid,
  input  logic                         load_ready,
  input  logic [DATA_W-1:0]            load_data,
  input  logic                         restart,
  output logic                         handshake,
  output logic                         imem_we,
  output logic [ADDR_W-1:0]            imem_waddr,
  output logic [DATA_W-1:0]            imem_wdata,
  output logic [$clog2(IMEM_DEPTH):0]  load_count,
  output logic                         load_error
);

  localparam int unsigned CNT_W = $clog2(IMEM_DEPTH) + 1;

  logic full;

  assign handshake  = load_valid & load_ready;
  // A reload from HALT starts over at word 0, so it can never overflow
  assign full       = ~restart & (load_count == CNT_W'(IMEM_DEPTH));
  assign imem_we    = handshake & ~full;
  assign imem_waddr = restart ? '0 : ADDR_W'({load_count, 2'b00});
  assign imem_wdata = load_data;

  // Word counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      load_count <= '0;
      load_error <= 1'b0;
    end else if (handshake) begin
      if (restart) begin
        load_count <= CNT_W'(1);
      end else if (full) begin
        load_error <= 1'b1;
      end else begin
        load_count <= load_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: loads the program image into IMEM, boots the
// core at RESET_PC, then steers the PC through normal fetch, redirects,
// hazard stalls and halt.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   load_valid/ready/data/last   NoC program-image stream
//   start                        begin execution once the image is loaded
//   hazard_stall                 freeze PC and IF/ID
//   branch_taken/branch_target   redirect from execute
//   halt_req                     core executed halt
//   imem_we/waddr/wdata          instruction memory write port
//   pc_we, pc_sel, pc_target     PC register enable, mux select, redirect address
//   flush_if_id                  squash IF/ID contents
//   state                        current FSM state code
//   load_count, load_error       loader status
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned        ADDR_W     = ADDR_W_DEF,
  parameter int unsigned        DATA_W     = INSTR_W,
  parameter int unsigned        IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter logic [ADDR_W-1:0]  RESET_PC   = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [DATA_W-1:0]            load_data,
  input  logic                         load_last,
  input  logic                         start,
  input  logic                         hazard_stall,
  input  logic                         branch_taken,
  input  logic [ADDR_W-1:0]            branch_target,
  input  logic                         halt_req,
  output logic                         imem_we,
  output logic [ADDR_W-1:0]            imem_waddr,
  output logic [DATA_W-1:0]            imem_wdata,
  output logic                         pc_we,
  output logic [1:0]                   pc_sel,
  output logic [ADDR_W-1:0]            pc_target,
  output logic                         flush_if_id,
  output logic [2:0]                   state,
  output logic [$clog2(IMEM_DEPTH):0]  load_count,
  output logic                         load_error
);

  // The PC register loads RESET_PC through the mux; it must be a word address
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_ctrl: RESET_PC must be word aligned");
  end

  state_t              state_q;
  state_t              state_d;
  logic                load_ready_q;
  logic [ADDR_W-1:0]   pc_target_q;
  logic                redirect;
  logic                handshake;
  logic                restart;

  assign state      = state_q;
  assign load_ready = load_ready_q;
  assign restart    = (state_q == ST_HALT);
  // Mux sees the live target on a redirect; the register keeps the last one
  assign pc_target  = redirect ? branch_target : pc_target_q;

  imem_loader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready_q),
    .load_data  (load_data),
    .restart    (restart),
    .handshake  (handshake),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .load_count (load_count),
    .load_error (load_error)
  );

  // State register, registered load_ready and debug copy of the redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      load_ready_q <= 1'b0;
      pc_target_q  <= '0;
    end else begin
      state_q      <= state_d;
      load_ready_q <= accepts_load(state_d);
      if (redirect) begin
        pc_target_q <= branch_target;
      end
    end
  end

  // Next state and PC steering
  always_comb begin
    state_d     = state_q;
    pc_we       = 1'b0;
    pc_sel      = PC_SEL_RESET;
    flush_if_id = 1'b0;
    redirect    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_LOAD, ST_HALT: begin
        if (handshake) begin
          state_d = load_last ? ST_READY : ST_LOAD;
        end
      end
      ST_READY: begin
        if (start) begin
          state_d = ST_BOOT;
        end
      end
      ST_BOOT: begin
        pc_we       = 1'b1;
        pc_sel      = PC_SEL_RESET;
        flush_if_id = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        pc_sel = PC_SEL_PLUS4;
        if (halt_req) begin
          flush_if_id = 1'b1;
          state_d     = ST_HALT;
        end else if (branch_taken) begin
          // Redirect wins over a simultaneous stall
          pc_we       = 1'b1;
          pc_sel      = PC_SEL_TARGET;
          flush_if_id = 1'b1;
          redirect    = 1'b1;
        end else if (!hazard_stall) begin
          pc_we = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
